// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit ALU opcodes and the RISC-V major opcodes
// for the OP (R-type) and OP-IMM (I-type) instruction groups.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of opcode/funct3/funct7_5 into the ALU opcode and
// operand-B selection controls; anything outside OP/OP-IMM is illegal.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       use_imm,
  output logic       is_shift,
  output logic       illegal
);

  logic is_r;
  logic is_i;

  always_comb begin
    is_r     = (opcode == OPC_R);
    is_i     = (opcode == OPC_I);
    illegal  = !(is_r || is_i);
    // Illegal instructions take the I-type operand path with an ADD.
    use_imm  = !is_r;
    is_shift = !is_r && ((funct3 == 3'b001) || (funct3 == 3'b101));
    alu_op   = ALU_ADD;
    if (!illegal) begin
      unique case (funct3)
        3'b000:  alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU instructions, resolves EX/MEM and MEM/WB
// bypasses, and holds one issued operation behind a valid/ready handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [4:0]       in_rd_addr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             flush,
  input  logic             fwd_ex_valid,
  input  logic [4:0]       fwd_ex_rd,
  input  logic [XLEN-1:0]  fwd_ex_data,
  input  logic             fwd_wb_valid,
  input  logic [4:0]       fwd_wb_rd,
  input  logic [XLEN-1:0]  fwd_wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [XLEN-1:0]  out_ina,
  output logic [XLEN-1:0]  out_inb,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [3:0]      dec_alu_op;
  logic            dec_use_imm;
  logic            dec_is_shift;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] opnd_b;
  logic            accept;

  alu_op_decoder u_dec (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .alu_op   (dec_alu_op),
    .use_imm  (dec_use_imm),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  // x0 always reads zero; the younger EX/MEM result wins over MEM/WB.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      addr,
                                              input logic [XLEN-1:0] rf_data,
                                              input logic            ex_v,
                                              input logic [4:0]      ex_rd,
                                              input logic [XLEN-1:0] ex_data,
                                              input logic            wb_v,
                                              input logic [4:0]      wb_rd,
                                              input logic [XLEN-1:0] wb_data);
    if (addr == 5'd0)                 return '0;
    else if (ex_v && (ex_rd == addr)) return ex_data;
    else if (wb_v && (wb_rd == addr)) return wb_data;
    else                              return rf_data;
  endfunction

  always_comb begin
    rs1_val = fwd_sel(in_rs1_addr, in_rs1_data, fwd_ex_valid, fwd_ex_rd,
                      fwd_ex_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    rs2_val = fwd_sel(in_rs2_addr, in_rs2_data, fwd_ex_valid, fwd_ex_rd,
                      fwd_ex_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    if (!dec_use_imm)     opnd_b = rs2_val;
    else if (dec_is_shift) opnd_b = {{(XLEN-5){1'b0}}, in_imm[4:0]};
    else                  opnd_b = in_imm;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush beats both the consume and any same-cycle accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_alu_op  <= ALU_ADD;
      out_ina     <= '0;
      out_inb     <= '0;
      out_rd      <= 5'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_alu_op  <= dec_alu_op;
      out_ina     <= rs1_val;
      out_inb     <= opnd_b;
      out_rd      <= dec_illegal ? 5'd0 : in_rd_addr;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule
